// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: parametrised ALU with registered result/flags and valid/ready
// handshakes on both sides. Multiply is an iterative shift-add taking WIDTH
// cycles, during which the block refuses new operations.
//
// Ports:
//   CLK        clock, all state updates on posedge
//   RST_N      synchronous active-low reset
//   A, B       operands (WIDTH bits)
//   Sel        operation select (3 bits)
//   in_valid   operands and Sel valid
//   in_ready   block can accept an operation this cycle
//   R          registered result (WIDTH bits)
//   Zflag      R == 0
//   Nflag      R[WIDTH-1]
//   Cflag      carry / borrow / multiply overflow
//   Vflag      signed overflow
//   out_valid  R and flags valid
//   out_ready  consumer takes the result
module alu_pipe_hs #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] R,
   output logic             Zflag,
   output logic             Nflag,
   output logic             Cflag,
   output logic             Vflag,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StMul} state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_lat;
   logic [WIDTH-1:0]   b_lat;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic               accept;
   logic               is_mul;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   res;
   logic               res_c;
   logic               res_v;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] acc_next;

   assign in_ready = (state == StIdle) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = MUL_EN && (Sel == 3'b011);

   // Single-cycle operations
   always_comb begin
      sum   = {1'b0, A} + {1'b0, B};
      diff  = {1'b0, A} - {1'b0, B};
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      unique case (Sel)
         3'b000: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         3'b001: res = A & B;
         3'b010: res = A | B;
         3'b011: res = '0;  // only reached when the multiplier is absent
         3'b100: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];  // borrow out == (A < B) unsigned
            res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         3'b101: res = {{(WIDTH-1){1'b0}}, (A < B)};
         3'b110: res = A ^ B;
         3'b111: res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         default: res = '0;
      endcase
   end

   // One shift-add iteration of the multiplier
   always_comb begin
      addend = '0;
      if (a_lat[cnt]) begin
         addend = {{WIDTH{1'b0}}, b_lat} << cnt;
      end
      acc_next = acc + addend;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= StIdle;
         R         <= '0;
         Zflag     <= 1'b0;
         Nflag     <= 1'b0;
         Cflag     <= 1'b0;
         Vflag     <= 1'b0;
         out_valid <= 1'b0;
         a_lat     <= '0;
         b_lat     <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         // Consumed result drops; a load below on the same edge overrides this
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            StIdle: begin
               if (accept) begin
                  if (is_mul) begin
                     a_lat <= A;
                     b_lat <= B;
                     acc   <= '0;
                     cnt   <= '0;
                     state <= StMul;
                  end else begin
                     R         <= res;
                     Zflag     <= (res == '0);
                     Nflag     <= res[WIDTH-1];
                     Cflag     <= res_c;
                     Vflag     <= res_v;
                     out_valid <= 1'b1;
                  end
               end
            end
            StMul: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               // out_valid is already 0 here: the mul accept required the
               // output slot to be free or drained on that edge.
               if (cnt == LastCnt) begin
                  R         <= acc_next[WIDTH-1:0];
                  Zflag     <= (acc_next[WIDTH-1:0] == '0);
                  Nflag     <= acc_next[WIDTH-1];
                  Cflag     <= |acc_next[2*WIDTH-1:WIDTH];
                  Vflag     <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
